// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / divide unit.
//   Multiply uses radix-2 Booth recoding, and divide uses restoring division
//   on magnitudes. Each takes CYCLES iterations plus one result cycle.
//   Division by zero skips the iterations and only raises div_zero.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle request, sampled only in IDLE
//   op           0 = signed multiply, 1 = signed divide
//   a_in, b_in   multiplicand/dividend and multiplier/divisor
//   busy         operation in flight (MULT, DIV or FIN)
//   done         one-cycle pulse; hi_out/lo_out are valid from this cycle
//   div_zero     divide by zero; held until the next accepted start
//   hi_out       mult: product high word, div: remainder
//   lo_out       mult: product low word,  div: quotient
module mult_div_unit #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(CYCLES);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_q;
    logic              a_neg;
    logic              b_neg;
    logic              dz_pend;

    // The Booth accumulator is one bit wider than the operands.
    // This keeps the multiplicand -2^(WIDTH-1) exact when it is added or
    // subtracted.
    logic signed [WIDTH:0] mcand;
    logic signed [WIDTH:0] acc;
    logic [WIDTH-1:0]      mq;
    logic                  q_m1;

    // Restoring divider.
    // quo starts as |dividend| and shifts its bits out into rem.
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return cond_neg(x, x[WIDTH-1]);
    endfunction

    // Booth add/subtract for the current recoding pair {q0, q-1}
    logic signed [WIDTH:0] acc_sum;
    always_comb begin
        acc_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   acc_sum = acc + mcand;
            2'b10:   acc_sum = acc - mcand;
            default: acc_sum = acc;
        endcase
    end

    // Trial subtraction.
    // rem < dvs always holds, so shifted fits in WIDTH+1 bits.
    // The difference fits in WIDTH bits whenever it is kept.
    logic [WIDTH:0]   shifted;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        rem_ge   = (shifted >= {1'b0, dvs});
        rem_diff = shifted[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            dz_pend  <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mq       <= '0;
            q_m1     <= 1'b0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        a_neg    <= a_in[WIDTH-1];
                        b_neg    <= b_in[WIDTH-1];
                        dz_pend  <= op && (b_in == '0);
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= CW'(CYCLES - 1);
                        mcand    <= {a_in[WIDTH-1], a_in};
                        acc      <= '0;
                        mq       <= b_in;
                        q_m1     <= 1'b0;
                        dvs      <= abs_val(b_in);
                        rem      <= '0;
                        quo      <= abs_val(a_in);
                        if (!op)
                            state <= MULT;
                        else if (b_in != '0)
                            state <= DIV;
                        else
                            state <= FIN;
                    end
                end
                MULT: begin
                    acc  <= acc_sum >>> 1;
                    mq   <= {acc_sum[0], mq[WIDTH-1:1]};
                    q_m1 <= mq[0];
                    if (cnt == '0)
                        state <= FIN;
                    else
                        cnt <= cnt - 1'b1;
                end
                DIV: begin
                    rem <= rem_ge ? rem_diff : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], rem_ge};
                    if (cnt == '0)
                        state <= FIN;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (dz_pend) begin
                        div_zero <= 1'b1;
                    end else if (op_q) begin
                        // Divide result: the quotient sign comes from the
                        // operand signs, the remainder sign from the dividend.
                        lo_out <= cond_neg(quo, a_neg ^ b_neg);
                        hi_out <= cond_neg(rem, a_neg);
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= mq;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    // Model state: the result registers keep their value across a divide by zero.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32), .CYCLES(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the signed operands
    task automatic model_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el,
                            output logic ed, output int elat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        elat = 34;
        if (!o) begin
            p = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'h0) begin
            eh = m_hi;
            el = m_lo;
            ed = 1'b1;
            elat = 2;
        end else begin
            q = sa / sb;
            r = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
        m_hi = eh;
        m_lo = el;
    endtask

    // Issue one operation and wait, with a cycle limit, for done.
    // lat counts the falling edges after the accepting edge.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        lat = 1;
        chk("busy_in_flight", {31'b0, busy}, 32'd1);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", lat);
        end
        hi = hi_out;
        lo = lo_out;
        dz = div_zero;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    logic [31:0] r_hi, r_lo, e_hi, e_lo;
    logic        r_dz, e_dz;
    int          r_lat, e_lat;
    int          pulses;

    initial begin
        tbl[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        tbl[2] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[4] = '{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
        tbl[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[6] = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        tbl[7] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0};
        tbl[8] = '{1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 32'h00000001, 1'b0};
        tbl[9] = '{1'b1, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r_hi, r_lo, r_dz, r_lat);
            chk($sformatf("tbl%0d_hi", i), r_hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), r_lo, tbl[i].lo);
            chk($sformatf("tbl%0d_dz", i), {31'b0, r_dz}, {31'b0, tbl[i].dz});
            chk($sformatf("tbl%0d_latency", i), r_lat, 32'd34);
        end

        // Divide by zero keeps the previous result
        run_op(1'b1, 32'h00000451, 32'h00000020, r_hi, r_lo, r_dz, r_lat);
        chk("prior_hi", r_hi, 32'h11);
        chk("prior_lo", r_lo, 32'h22);
        run_op(1'b1, 32'h00000005, 32'h00000000, r_hi, r_lo, r_dz, r_lat);
        chk("dz_hi", r_hi, 32'h11);
        chk("dz_lo", r_lo, 32'h22);
        chk("dz_flag", {31'b0, r_dz}, 32'd1);
        chk("dz_latency", r_lat, 32'd2);
        chk("dz_flag_held", {31'b0, div_zero}, 32'd1);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd6; b_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("dz_cleared_by_start", {31'b0, div_zero}, 32'd0);
        r_lat = 1;
        while (!done && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
        end
        chk("mult_after_dz_lo", lo_out, 32'd42);
        chk("mult_after_dz_hi", hi_out, 32'd0);

        // Overflow divide with an ignored start at cycle 10
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'h80000000; b_in = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        pulses = 0;
        for (int c = 1; c < 80; c++) begin
            if (c == 10) begin
                start = 1'b1; op = 1'b0; a_in = 32'd2; b_in = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                r_hi = hi_out;
                r_lo = lo_out;
                r_dz = div_zero;
            end
            @(negedge clk);
        end
        chk("ovf_done_pulses", pulses, 32'd1);
        chk("ovf_lo", r_lo, 32'h80000000);
        chk("ovf_hi", r_hi, 32'h0);
        chk("ovf_dz", {31'b0, r_dz}, 32'd0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'h12345; b_in = 32'h6789;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("async_done", {31'b0, done}, 32'd0);
        chk("async_hi", hi_out, 32'd0);
        chk("async_lo", lo_out, 32'd0);
        chk("async_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("no_done_after_reset", pulses, 32'd0);
        run_op(1'b0, 32'd3, 32'd4, r_hi, r_lo, r_dz, r_lat);
        chk("post_reset_lo", r_lo, 32'd12);
        chk("post_reset_hi", r_hi, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd12;

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        ro;
            logic [31:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'h7FFFFFFF;
                2:       ra = 32'($signed(-$urandom_range(0, 100)));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            model_op(ro, ra, rb, e_hi, e_lo, e_dz, e_lat);
            run_op(ro, ra, rb, r_hi, r_lo, r_dz, r_lat);
            chk($sformatf("rnd%0d_hi", i), r_hi, e_hi);
            chk($sformatf("rnd%0d_lo", i), r_lo, e_lo);
            chk($sformatf("rnd%0d_dz", i), {31'b0, r_dz}, {31'b0, e_dz});
            chk($sformatf("rnd%0d_latency", i), r_lat, e_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
